// File: rtl/inst_loader.sv
// Boot-time instruction memory loader: assembles big-endian words from a byte
// stream, writes them to consecutive word addresses and holds the core in reset.
module inst_loader #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   word_count,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              im_we,
  output logic [31:0]       im_addr,
  output logic [31:0]       im_wdata,
  output logic              cpu_rst_n,
  output logic              busy,
  output logic              done,
  output logic [7:0]        checksum
);

  localparam logic [ADDR_W:0] DEPTH   = {1'b1, {ADDR_W{1'b0}}};
  localparam int unsigned     ADDR_PAD = 30 - ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RECV,
    S_WRITE,
    S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic [1:0]          byte_idx_q, byte_idx_d;
  logic [ADDR_W-1:0]   word_idx_q, word_idx_d;
  logic [31:0]         word_q, word_d;
  logic [7:0]          checksum_q, checksum_d;
  logic                cpu_rst_n_q, cpu_rst_n_d;

  logic [ADDR_W:0]     cnt_clamped;
  logic [ADDR_W:0]     word_idx_inc;

  always_comb begin
    cnt_clamped  = (word_count > DEPTH) ? DEPTH : word_count;
    // One bit wider than word_idx so the final index equals DEPTH without wrapping.
    word_idx_inc = {1'b0, word_idx_q} + (ADDR_W+1)'(1);
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    byte_idx_d  = byte_idx_q;
    word_idx_d  = word_idx_q;
    word_d      = word_q;
    checksum_d  = checksum_q;
    cpu_rst_n_d = cpu_rst_n_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          cnt_d       = cnt_clamped;
          checksum_d  = '0;
          byte_idx_d  = '0;
          word_idx_d  = '0;
          cpu_rst_n_d = 1'b0;
          state_d     = (cnt_clamped == '0) ? S_DONE : S_RECV;
        end
      end
      S_RECV: begin
        if (byte_valid) begin
          word_d     = {word_q[23:0], byte_data};
          checksum_d = checksum_q ^ byte_data;
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        word_idx_d = word_idx_inc[ADDR_W-1:0];
        byte_idx_d = '0;
        state_d    = (word_idx_inc == cnt_q) ? S_DONE : S_RECV;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Release overrides the start-time clear so a zero-count session still releases.
    if (state_d == S_DONE) begin
      cpu_rst_n_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      byte_idx_q  <= '0;
      word_idx_q  <= '0;
      word_q      <= '0;
      checksum_q  <= '0;
      cpu_rst_n_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      byte_idx_q  <= byte_idx_d;
      word_idx_q  <= word_idx_d;
      word_q      <= word_d;
      checksum_q  <= checksum_d;
      cpu_rst_n_q <= cpu_rst_n_d;
    end
  end

  always_comb begin
    byte_ready = (state_q == S_RECV);
    im_we      = (state_q == S_WRITE);
    busy       = (state_q == S_RECV) || (state_q == S_WRITE);
    done       = (state_q == S_DONE);
    im_addr    = im_we ? {{ADDR_PAD{1'b0}}, word_idx_q, 2'b00} : '0;
    im_wdata   = im_we ? word_q : '0;
    checksum   = checksum_q;
    cpu_rst_n  = cpu_rst_n_q;
  end

endmodule

// File: tb/tb_inst_loader.sv
// Scoreboard bench for inst_loader: expected writes are queued as bytes are
// driven and matched against every im_we strobe.
module tb_inst_loader;

  localparam int unsigned AW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW:0]   word_count;
  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          byte_ready;
  logic          im_we;
  logic [31:0]   im_addr;
  logic [31:0]   im_wdata;
  logic          cpu_rst_n;
  logic          busy;
  logic          done;
  logic [7:0]    checksum;

  always #5 clk = ~clk;

  inst_loader #(.ADDR_W(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .word_count (word_count),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .im_we      (im_we),
    .im_addr    (im_addr),
    .im_wdata   (im_wdata),
    .cpu_rst_n  (cpu_rst_n),
    .busy       (busy),
    .done       (done),
    .checksum   (checksum)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  logic [7:0]  exp_cs;
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Every write strobe must match the oldest outstanding expected write.
  always @(negedge clk) begin
    wr_t e;
    if (rst && im_we) begin
      if (exp_q.size() == 0) begin
        check("unexpected_we", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("we_addr", im_addr, e.addr);
        check("we_data", im_wdata, e.data);
        check("we_busy", 32'(busy), 32'd1);
      end
    end
  end

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic send_byte(input logic [7:0] b);
    byte_valid = 1'b1;
    byte_data  = b;
    for (int i = 0; i < 20; i++) begin
      if (byte_ready) begin
        @(posedge clk);
        @(negedge clk);
        return;
      end
      @(negedge clk);
    end
    check("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 32'(byte_ready), 32'd0);
    check({tag, "_we"},    32'(im_we),      32'd0);
    check({tag, "_addr"},  im_addr,         32'd0);
    check({tag, "_wdata"}, im_wdata,        32'd0);
    check({tag, "_cpurst"},32'(cpu_rst_n),  32'd0);
    check({tag, "_busy"},  32'(busy),       32'd0);
    check({tag, "_done"},  32'(done),       32'd0);
    check({tag, "_cs"},    32'(checksum),   32'd0);
  endtask

  task automatic run_session(input int wc, input int nexp, input bit stalls,
                             input bit abuse, input bit fixed);
    logic [7:0]  bytes [4];
    logic [31:0] w;
    start      = 1'b1;
    word_count = wc[AW:0];
    byte_valid = abuse;
    byte_data  = 8'hEE;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    exp_cs = 8'h00;
    if (nexp == 0) begin
      check("zero_done",   32'(done),      32'd1);
      check("zero_cpurst", 32'(cpu_rst_n), 32'd1);
      check("zero_busy",   32'(busy),      32'd0);
      check("zero_cs",     32'(checksum),  32'd0);
      @(negedge clk);
      check("zero_done_pulse", 32'(done), 32'd0);
    end else begin
      check("start_ready",  32'(byte_ready), 32'd1);
      check("start_busy",   32'(busy),       32'd1);
      check("start_cpurst", 32'(cpu_rst_n),  32'd0);
      check("start_cs",     32'(checksum),   32'd0);
      for (int wi = 0; wi < nexp; wi++) begin
        for (int b = 0; b < 4; b++) begin
          bytes[b] = 8'($urandom);
        end
        if (fixed && wi == 0) begin
          bytes[0] = 8'h20; bytes[1] = 8'h08; bytes[2] = 8'h00; bytes[3] = 8'h05;
        end
        w = {bytes[0], bytes[1], bytes[2], bytes[3]};
        exp_cs = exp_cs ^ bytes[0] ^ bytes[1] ^ bytes[2] ^ bytes[3];
        exp_q.push_back('{addr: 32'(wi * 4), data: w});
        for (int b = 0; b < 4; b++) begin
          if (stalls) begin
            byte_valid = 1'b0;
            repeat ($urandom_range(0, 3)) @(negedge clk);
          end
          if (abuse && wi == 0 && b == 2) begin
            byte_valid = 1'b0;
            start      = 1'b1;
            word_count = 1;
            @(negedge clk);
            start = 1'b0;
          end
          send_byte(bytes[b]);
        end
        if (abuse) begin
          byte_valid = 1'b1;
          byte_data  = 8'hA5;
          if (wi != nexp - 1) @(negedge clk);
        end
      end
      @(negedge clk);
      check("fin_done",   32'(done),       32'd1);
      check("fin_cpurst", 32'(cpu_rst_n),  32'd1);
      check("fin_busy",   32'(busy),       32'd0);
      check("fin_ready",  32'(byte_ready), 32'd0);
      check("fin_cs",     32'(checksum),   32'(exp_cs));
      check("fin_drained",32'(exp_q.size()), 32'd0);
      @(negedge clk);
      check("post_done",   32'(done),      32'd0);
      check("post_cpurst", 32'(cpu_rst_n), 32'd1);
      check("post_ready",  32'(byte_ready),32'd0);
    end
    byte_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b0;
    start      = 1'b0;
    word_count = '0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    #1 check_reset_outputs("por");
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("idle_cpurst", 32'(cpu_rst_n), 32'd0);

    // single word with known bytes
    run_session(1, 1, 1'b0, 1'b0, 1'b1);
    check("single_cs", 32'(checksum), 32'h2D);

    // zero count
    run_session(0, 0, 1'b0, 1'b0, 1'b0);

    // multi-word with random valid gaps
    run_session(3, 3, 1'b1, 1'b0, 1'b0);

    // reload with protocol abuse
    run_session(2, 2, 1'b0, 1'b1, 1'b0);

    // clamp: 12 > DEPTH=8
    run_session(12, 8, 1'b1, 1'b0, 1'b0);

    // mid-session asynchronous reset
    start      = 1'b1;
    word_count = 2;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    send_byte(8'h12);
    send_byte(8'h34);
    check("mid_cs", 32'(checksum), 32'h26);
    byte_valid = 1'b0;
    #2 rst = 1'b0;
    #1 check_reset_outputs("mid_rst");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run_session(1, 1, 1'b0, 1'b0, 1'b0);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_loader.md
# inst_loader

Boot-time writer for the processor's instruction memory. Accepts a byte stream over a valid/ready handshake, assembles big-endian 32-bit words, and writes them to consecutive word-aligned instruction addresses starting at 0. Holds the processor core in reset while loading and releases it when the programmed word count has been written. Sits between the host byte link and the write port of the instruction memory; the core's fetch port is the reader side of the same memory.

## Interface

**Parameters**
- `ADDR_W`, default 8: word-address bits. Memory depth `DEPTH = 2**ADDR_W` words.

**Ports**
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: begin a load session. Sampled only in IDLE.
- `word_count`, input, ADDR_W+1: number of words to load. Latched on accepted `start`.
- `byte_valid`, input, 1: `byte_data` holds a valid byte.
- `byte_data`, input, 8: stream byte, most-significant byte of each word first.
- `byte_ready`, output, 1: loader can accept a byte this cycle.
- `im_we`, output, 1: instruction memory write enable, single-cycle strobe.
- `im_addr`, output, 32: byte address, `{word_idx, 2'b00}`, zero-extended.
- `im_wdata`, output, 32: assembled instruction word.
- `cpu_rst_n`, output, 1: active-low reset to the processor core.
- `busy`, output, 1: high in RECV and WRITE.
- `done`, output, 1: one-cycle pulse when a session completes.
- `checksum`, output, 8: running XOR of all bytes accepted in the current or last session.

## Operation

- **Reset values:** state = IDLE, `byte_ready` = 0, `im_we` = 0, `im_addr` = 0, `im_wdata` = 0, `cpu_rst_n` = 0, `busy` = 0, `done` = 0, `checksum` = 0. Internal byte_idx and word_idx = 0.
- **Core reset after reset:** the core stays in reset until the first session completes.
- **IDLE**
  - `start` = 1: latch `min(word_count, DEPTH)` into `cnt`, clear `checksum`, byte_idx and word_idx, and drive `cpu_rst_n` = 0.
  - If `cnt` == 0, go to DONE. Otherwise go to RECV.
- **RECV**
  - `byte_ready` = 1.
  - On `byte_valid` & `byte_ready`: `word <= {word[23:0], byte_data}`, `checksum <= checksum ^ byte_data`, byte_idx++.
  - On the 4th accepted byte (byte_idx == 3), go to WRITE.
  - `byte_valid` low inserts stall cycles with no state change.
- **WRITE** (exactly one cycle)
  - `im_we` = 1, `im_addr` = word_idx×4, `im_wdata` = word, `byte_ready` = 0.
  - word_idx++ and byte_idx = 0.
  - If word_idx+1 == `cnt`, go to DONE. Otherwise go to RECV.
- **DONE** (one cycle)
  - `done` = 1.
  - `cpu_rst_n` goes to 1 on entry to DONE and stays 1 until the next accepted `start`.
  - Then go to IDLE.
- **Ignored and excess input:**
  - `start` outside IDLE is ignored.
  - Bytes presented outside RECV are not accepted, because `byte_ready` = 0.
- **Overflow:** `word_count` > DEPTH is clamped to DEPTH. `im_addr` never exceeds (DEPTH−1)×4, so there is no wrap-around.
- **Reset mid-session:** all state returns to reset values immediately.
  - The partial word is discarded.
  - `cpu_rst_n` = 0, so the core stays held until a complete new session finishes.
  - Words already written remain in memory.

## Timing

- `im_we`, `im_addr`, `im_wdata` and `done` are registered and combinationally decoded from state only.
- `byte_ready` is a function of state only; it does not depend on `byte_valid`.
- **Start to RECV:** `start` sampled at edge N, then `byte_ready` = 1 in cycle N+1.
- **Throughput:** with `byte_valid` held high, each word takes 5 cycles (4 accept + 1 WRITE). A session takes 5×`cnt` cycles from first `byte_ready` to the last `im_we`. DONE follows on the next cycle.
- **Zero count:** `start` with `word_count` = 0 gives `done` in cycle N+1, with no `im_we`.
- **Write to release:** the cycle after the final `im_we`, `done` = 1 and `cpu_rst_n` = 1 at the same time.
- **Reset:** `rst` asserted clears outputs asynchronously, with no clock needed. Deassertion is synchronous to the design's reset synchronizer, which is outside this block.

## Test plan

- **Reset check:** assert `rst` = 0 mid-RECV after 2 bytes. Expect all outputs at reset values without a clock edge. Then run a full session and confirm no stale bytes leak into the first word.
- **Single word:** `word_count` = 1, bytes 0x20,0x08,0x00,0x05 back-to-back.
  - Expect `im_we` for one cycle with `im_addr` = 0 and `im_wdata` = 0x20080005.
  - Expect `done` and `cpu_rst_n` rising the next cycle, and `checksum` = 0x20^0x08^0x00^0x05 = 0x2D.
- **Multi-word with stalls:** `word_count` = 3, random `byte_valid` gaps. Expect writes at 0x0, 0x4, 0x8 in order, data matching the stream, and no acceptance while `byte_valid` = 0.
- **Zero count and clamp:**
  - `word_count` = 0: expect `done` one cycle after `start`, no `im_we`, and `cpu_rst_n` = 1.
  - `ADDR_W` = 2, `word_count` = 9: expect exactly 4 writes, last at `im_addr` = 0xC.
- **Protocol abuse:** pulse `start` during RECV and drive `byte_valid` high during WRITE, DONE and IDLE. Expect no restart, no extra bytes accepted, and byte ordering intact.
- **Reload:** after one completed session, `start` again with `word_count` = 2. Expect `cpu_rst_n` to drop the cycle after `start` and rise only with the new `done`, with `checksum` cleared at start.
